unibusarb: RTL and testbench

Unibus grant arbiter that sits directly downstream of the switch/light DMA master and the other bus-requesting devices. It receives their NPR and BR4–BR7 requests, drives the NPG and BG4–BG7 grant lines, and handles the SACK/BBSY handshake. A grant that nobody acknowledges is dropped after a timeout. The ARM processor enables the block and reads its status and counters through the same three-bit register port used by the other Zynq-side blocks.

---
 rtl/unibusarb.sv | 211 +++++++++++++++++++++
 tb/tb_unibusarb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/unibusarb.sv
// Unibus NPR/BR4-BR7 grant arbiter with SACK/BBSY handshake, grant timeout and ARM register port.
// Macro UNIBUSARB_BR_EN enables BR arbitration; when undefined only NPR is ever granted.
module unibusarb #(
    parameter int unsigned GRTMO   = 1023,
    parameter int unsigned HOLDOFF = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        init_in_h,
    input  logic        npr_in_h,
    input  logic [3:0]  br_in_h,
    input  logic        sack_in_h,
    input  logic        bbsy_in_h,
    input  logic [2:0]  cpupri_in,
    input  logic        instbnd_in_h,
    output logic        npg_out_l,
    output logic [3:0]  bg_out_l,
    output logic        busy_out_h
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSettle = 3'd1,
        StGrant  = 3'd2,
        StTenure = 3'd3,
        StHold   = 3'd4
    } state_e;

    localparam logic [3:0]  GntNpr   = 4'h0;
    localparam logic [3:0]  GntNone  = 4'hF;
    localparam logic [15:0] GrtmoVal = 16'(GRTMO);
    localparam logic [15:0] HoldVal  = 16'(HOLDOFF);
    localparam logic [15:0] SettleLast = 16'd3;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  win_q, win_d;
    logic [3:0]  lastgnt_q, lastgnt_d;
    logic        enable_q, enable_d;
    logic [15:0] tmocnt_q, tmocnt_d;
    logic [15:0] nprcnt_q, nprcnt_d;
    logic [15:0] brcnt_q, brcnt_d;

    logic [3:0]  br_elig;
    logic [3:0]  win;
    logic        win_vld;

    always_comb begin
        br_elig = '0;
`ifdef UNIBUSARB_BR_EN
        for (int n = 4; n < 8; n++) begin
            br_elig[n-4] = br_in_h[n-4] && instbnd_in_h && (3'(n) > cpupri_in);
        end
`endif
    end

`ifndef UNIBUSARB_BR_EN
    logic unused_br;
    assign unused_br = ^{instbnd_in_h, cpupri_in};
`endif

    always_comb begin
        win_vld = 1'b1;
        if (npr_in_h)        win = GntNpr;
        else if (br_elig[3]) win = 4'd7;
        else if (br_elig[2]) win = 4'd6;
        else if (br_elig[1]) win = 4'd5;
        else if (br_elig[0]) win = 4'd4;
        else begin
            win     = GntNone;
            win_vld = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        lastgnt_d = lastgnt_q;
        enable_d  = enable_q;
        tmocnt_d  = tmocnt_q;
        nprcnt_d  = nprcnt_q;
        brcnt_d   = brcnt_q;

        unique case (state_q)
            StIdle: begin
                if (enable_q && !bbsy_in_h && !sack_in_h && win_vld) begin
                    state_d = StSettle;
                    win_d   = win;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (!enable_q) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (!win_vld || win != win_q) begin
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    state_d   = StGrant;
                    cnt_d     = '0;
                    lastgnt_d = win_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGrant: begin
                if (!enable_q) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (sack_in_h) begin
                    state_d = StTenure;
                    cnt_d   = '0;
                    if (win_q == GntNpr) begin
                        if (nprcnt_q != 16'hFFFF) nprcnt_d = nprcnt_q + 16'd1;
                    end else begin
                        if (brcnt_q != 16'hFFFF) brcnt_d = brcnt_q + 16'd1;
                    end
                end else if (cnt_q == GrtmoVal) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    if (tmocnt_q != 16'hFFFF) tmocnt_d = tmocnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StTenure: begin
                if (!sack_in_h && !bbsy_in_h) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == HoldVal) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // INIT drops the bus cleanly but leaves counters and enable untouched, even over a write.
        if (init_in_h) begin
            state_d  = StIdle;
            cnt_d    = '0;
            tmocnt_d = tmocnt_q;
            nprcnt_d = nprcnt_q;
            brcnt_d  = brcnt_q;
        end else if (armwrite && armwaddr == 3'd1) begin
            enable_d = armwdata[31];
            if (armwdata[30]) begin
                tmocnt_d = '0;
                nprcnt_d = '0;
                brcnt_d  = '0;
            end
        end
`ifndef UNIBUSARB_BR_EN
        brcnt_d = '0;
`endif
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            win_q     <= GntNone;
            lastgnt_q <= GntNone;
            enable_q  <= 1'b0;
            tmocnt_q  <= '0;
            nprcnt_q  <= '0;
            brcnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            lastgnt_q <= lastgnt_d;
            enable_q  <= enable_d;
            tmocnt_q  <= tmocnt_d;
            nprcnt_q  <= nprcnt_d;
            brcnt_q   <= brcnt_d;
        end
    end

    assign busy_out_h = (state_q != StIdle);
    assign npg_out_l  = !(state_q == StGrant && win_q == GntNpr);

`ifdef UNIBUSARB_BR_EN
    always_comb begin
        bg_out_l = 4'hF;
        if (state_q == StGrant && win_q != GntNpr) bg_out_l[win_q[1:0]] = 1'b0;
    end
`else
    assign bg_out_l = 4'hF;
`endif

    always_comb begin
        case (armraddr)
            3'd0:    armrdata = 32'h4241_1001;
            3'd1:    armrdata = {enable_q, 3'b000, 3'(state_q), 1'b0, lastgnt_q, 4'b0000, tmocnt_q};
            3'd2:    armrdata = {nprcnt_q, brcnt_q};
            3'd3:    armrdata = {27'd0, npr_in_h, br_in_h};
            default: armrdata = 32'hDEAD_BEEF;
        endcase
    end
endmodule

// File: tb/tb_unibusarb.sv
// Directed bench for unibusarb: arbitration vector table plus handshake, timeout and INIT sequences.
module tb_unibusarb;
`ifdef UNIBUSARB_BR_EN
    localparam bit BrEn = 1'b1;
`else
    localparam bit BrEn = 1'b0;
`endif
    localparam logic [2:0] SIdle = 3'd0, SSettle = 3'd1, STenure = 3'd3, SHold = 3'd4;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        armwrite;
    logic [2:0]  armraddr, armwaddr;
    logic [31:0] armwdata, armrdata;
    logic        init_in_h, npr_in_h, sack_in_h, bbsy_in_h, instbnd_in_h;
    logic [3:0]  br_in_h;
    logic [2:0]  cpupri_in;
    logic        npg_out_l, busy_out_h;
    logic [3:0]  bg_out_l;

    int checks = 0;
    int errors = 0;

    unibusarb #(.GRTMO(1023), .HOLDOFF(15)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
        .init_in_h(init_in_h), .npr_in_h(npr_in_h), .br_in_h(br_in_h),
        .sack_in_h(sack_in_h), .bbsy_in_h(bbsy_in_h), .cpupri_in(cpupri_in),
        .instbnd_in_h(instbnd_in_h), .npg_out_l(npg_out_l), .bg_out_l(bg_out_l),
        .busy_out_h(busy_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       npr;
        logic [3:0] br;
        logic [2:0] pri;
        logic       inst;
        logic       exp_npg;
        logic [3:0] exp_bg;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic wr(input logic [31:0] d);
        armwaddr = 3'd1;
        armwdata = d;
        armwrite = 1'b1;
        tick(1);
        armwrite = 1'b0;
    endtask

    function automatic logic [31:0] st(input logic en, input logic [2:0] s, input logic [3:0] lg,
                                       input logic [15:0] tmo);
        return {en, 3'b000, s, 1'b0, lg, 4'b0000, tmo};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        exp_grant;
        int          lowcnt;

        vecs[0] = '{1'b0, 4'b1010, 3'd5, 1'b1, 1'b1, BrEn ? 4'b0111 : 4'hF};
        vecs[1] = '{1'b0, 4'b1010, 3'd7, 1'b1, 1'b1, 4'hF};
        vecs[2] = '{1'b0, 4'b1111, 3'd3, 1'b0, 1'b1, 4'hF};
        vecs[3] = '{1'b0, 4'b0001, 3'd3, 1'b1, 1'b1, BrEn ? 4'b1110 : 4'hF};
        vecs[4] = '{1'b0, 4'b0001, 3'd4, 1'b1, 1'b1, 4'hF};
        vecs[5] = '{1'b1, 4'b1111, 3'd0, 1'b1, 1'b0, 4'hF};
        vecs[6] = '{1'b0, 4'b0110, 3'd0, 1'b1, 1'b1, BrEn ? 4'b1011 : 4'hF};
        vecs[7] = '{1'b0, 4'b0010, 3'd4, 1'b1, 1'b1, BrEn ? 4'b1101 : 4'hF};
        vecs[8] = '{1'b0, 4'b1111, 3'd0, 1'b1, 1'b1, BrEn ? 4'b0111 : 4'hF};

        RESET = 1'b1; armwrite = 1'b0; armraddr = 3'd0; armwaddr = 3'd0; armwdata = '0;
        init_in_h = 1'b0; npr_in_h = 1'b0; br_in_h = 4'h0; sack_in_h = 1'b0;
        bbsy_in_h = 1'b0; cpupri_in = 3'd0; instbnd_in_h = 1'b0;
        tick(3);
        RESET = 1'b0;
        tick(1);

        chk("reset_npg", npg_out_l, 1'b1);
        chk("reset_bg", bg_out_l, 4'hF);
        chk("reset_busy", busy_out_h, 1'b0);
        rd(3'd0, d); chk("reg_id", d, 32'h4241_1001);
        rd(3'd1, d); chk("reset_status", d, st(1'b0, SIdle, 4'hF, 16'd0));
        rd(3'd2, d); chk("reset_counts", d, 32'd0);
        rd(3'd6, d); chk("reg_bad", d, 32'hDEAD_BEEF);

        // Disabled arbiter ignores requests.
        npr_in_h = 1'b1;
        tick(6);
        chk("disabled_npg", npg_out_l, 1'b1);
        chk("disabled_busy", busy_out_h, 1'b0);
        npr_in_h = 1'b0;
        wr(32'h8000_0000);
        rd(3'd1, d); chk("enable_status", d, st(1'b1, SIdle, 4'hF, 16'd0));

        // NPR with SACK 3 cycles after grant and BBSY for 20 cycles.
        npr_in_h = 1'b1;
        tick(4);
        chk("npr_settle_npg", npg_out_l, 1'b1);
        rd(3'd1, d); chk("npr_settle_state", d[27:25], SSettle);
        tick(1);
        chk("npr_grant_edge5", npg_out_l, 1'b0);
        npr_in_h = 1'b0;
        tick(3);
        chk("npr_grant_g3", npg_out_l, 1'b0);
        sack_in_h = 1'b1; bbsy_in_h = 1'b1;
        tick(1);
        chk("npr_sack_drop", npg_out_l, 1'b1);
        rd(3'd1, d); chk("npr_tenure", d[27:25], STenure);
        sack_in_h = 1'b0;
        tick(19);
        bbsy_in_h = 1'b0;
        rd(3'd1, d); chk("npr_tenure_end", d[27:25], STenure);
        tick(1);
        rd(3'd1, d); chk("npr_hold_first", d[27:25], SHold);
        tick(15);
        rd(3'd1, d); chk("npr_hold_last", d[27:25], SHold);
        tick(1);
        chk("npr_idle_busy", busy_out_h, 1'b0);
        rd(3'd2, d); chk("npr_count", d, 32'h0001_0000);

        for (int i = 0; i < 9; i++) begin
            npr_in_h = vecs[i].npr; br_in_h = vecs[i].br;
            cpupri_in = vecs[i].pri; instbnd_in_h = vecs[i].inst;
            exp_grant = !vecs[i].exp_npg || (vecs[i].exp_bg != 4'hF);
            tick(5);
            chk($sformatf("vec%0d_npg", i), npg_out_l, vecs[i].exp_npg);
            chk($sformatf("vec%0d_bg", i), bg_out_l, vecs[i].exp_bg);
            rd(3'd3, d); chk($sformatf("vec%0d_raddr3", i), d, {27'd0, vecs[i].npr, vecs[i].br});
            if (exp_grant) begin
                sack_in_h = 1'b1;
                tick(1);
                sack_in_h = 1'b0;
            end
            npr_in_h = 1'b0; br_in_h = 4'h0;
            tick(20);
            chk($sformatf("vec%0d_idle", i), busy_out_h, 1'b0);
        end
        rd(3'd2, d); chk("table_counts", d, {16'd2, BrEn ? 16'd5 : 16'd0});

        // Two-cycle NPR glitch never reaches grant.
        npr_in_h = 1'b1;
        tick(2);
        npr_in_h = 1'b0;
        tick(1);
        rd(3'd1, d); chk("short_npr_state", d[27:25], SIdle);
        tick(4);
        chk("short_npr_npg", npg_out_l, 1'b1);

        // Unacknowledged grant times out after GRTMO+1 cycles.
        npr_in_h = 1'b1;
        tick(5);
        lowcnt = 0;
        while (npg_out_l == 1'b0 && lowcnt < 2000) begin
            lowcnt++;
            tick(1);
        end
        npr_in_h = 1'b0;
        chk("tmo_low_cycles", lowcnt, 1024);
        rd(3'd1, d); chk("tmo_status", d, st(1'b1, SHold, 4'h0, 16'd1));
        tick(15);
        chk("tmo_hold_busy", busy_out_h, 1'b1);
        tick(1);
        chk("tmo_idle", busy_out_h, 1'b0);

        // INIT during grant wins over a simultaneous counter-clear write.
        npr_in_h = 1'b1;
        tick(5);
        chk("init_pre_grant", npg_out_l, 1'b0);
        tick(2);
        init_in_h = 1'b1; npr_in_h = 1'b0;
        armwaddr = 3'd1; armwdata = 32'h4000_0000; armwrite = 1'b1;
        tick(1);
        init_in_h = 1'b0; armwrite = 1'b0;
        chk("init_npg", npg_out_l, 1'b1);
        rd(3'd1, d); chk("init_status", d, st(1'b1, SIdle, 4'h0, 16'd1));
        rd(3'd2, d); chk("init_counts", d, {16'd2, BrEn ? 16'd5 : 16'd0});
        wr(32'hC000_0000);
        rd(3'd2, d); chk("clear_counts", d, 32'd0);
        rd(3'd1, d); chk("clear_status", d, st(1'b1, SIdle, 4'h0, 16'd0));

        // Disabling during grant withdraws it and enters HOLD.
        npr_in_h = 1'b1;
        tick(5);
        chk("dis_pre_grant", npg_out_l, 1'b0);
        wr(32'h0000_0000);
        tick(1);
        npr_in_h = 1'b0;
        chk("dis_npg", npg_out_l, 1'b1);
        rd(3'd1, d); chk("dis_status", d, st(1'b0, SHold, 4'h0, 16'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
